// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters.
// Latches the winner's payload, strobes tx_send and tracks the frame until the line is idle.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned DATA_MAX_LEN = 1
) (
   input  logic                           clk,
   input  logic                           res_n,
   input  logic [N_REQ-1:0]               req,
   input  logic [N_REQ*DATA_MAX_LEN*8-1:0] req_data,
   input  logic [N_REQ*32-1:0]            req_len_1,
   output logic [N_REQ-1:0]               grant,
   output logic [N_REQ-1:0]               done,
   output logic [N_REQ-1:0]               owner,
   output logic                           busy,
   output logic                           err,
   output logic [DATA_MAX_LEN*8-1:0]      tx_data,
   output logic [31:0]                    tx_len_1,
   output logic                           tx_send,
   input  logic                           tx_ready
);

   localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned DW      = DATA_MAX_LEN * 8;
   localparam logic [31:0] LEN_MAX = 32'(DATA_MAX_LEN - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] last, owner_idx, win_idx, cand;
   logic             win_vld;
   logic             take;
   logic [2:0]       wd_cnt;
   logic [31:0]      sel_len;
   logic [DW-1:0]    sel_data;

   // Scan from the requester after the last one served, wrapping, so last itself is checked last.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = IDX_W'((32'(last) + i) % N_REQ);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // res_n gates the combinational grant so it stays low throughout reset.
   assign take     = (state == IDLE) && tx_ready && win_vld && res_n;
   assign grant    = take ? (N_REQ'(1) << win_idx) : '0;
   assign sel_data = req_data[win_idx*DW +: DW];
   assign sel_len  = req_len_1[win_idx*32 +: 32];

   assign busy    = (state != IDLE);
   assign tx_send = (state == ISSUE);
   assign done    = (state == DONE) ? owner : '0;
   assign err     = (state == WAIT_START) && tx_ready && (wd_cnt == 3'd4);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (take) state_nxt = ISSUE;
         ISSUE:      state_nxt = WAIT_START;
         WAIT_START: begin
            if (!tx_ready)           state_nxt = WAIT_DONE;
            else if (wd_cnt == 3'd4) state_nxt = IDLE;
         end
         WAIT_DONE:  if (tx_ready) state_nxt = DONE;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state     <= IDLE;
         last      <= IDX_W'(N_REQ - 1);
         owner     <= '0;
         owner_idx <= '0;
         wd_cnt    <= '0;
         tx_data   <= '0;
         tx_len_1  <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            owner     <= grant;
            owner_idx <= win_idx;
            tx_data   <= sel_data;
            tx_len_1  <= (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
         end
         if (state == ISSUE)
            wd_cnt <= '0;
         else if (state == WAIT_START)
            wd_cnt <= wd_cnt + 3'd1;
         // Watchdog expiry drops ownership but leaves last alone, so no rotation.
         if (err)
            owner <= '0;
         if (state == DONE) begin
            last  <= owner_idx;
            owner <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, DATA_MAX_LEN=2) with hand-computed expectations.
module tb_uart_tx_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned L  = 2;
   localparam int unsigned DW = L * 8;

   logic              clk = 1'b0;
   logic              res_n;
   logic [N-1:0]      req;
   logic [N*DW-1:0]   req_data;
   logic [N*32-1:0]   req_len_1;
   logic [N-1:0]      grant, done, owner;
   logic              busy, err, tx_send, tx_ready;
   logic [DW-1:0]     tx_data;
   logic [31:0]       tx_len_1;

   int unsigned tests = 0;
   int unsigned fails = 0;

   uart_tx_arbiter #(.N_REQ(N), .DATA_MAX_LEN(L)) dut (
      .clk(clk), .res_n(res_n), .req(req), .req_data(req_data), .req_len_1(req_len_1),
      .grant(grant), .done(done), .owner(owner), .busy(busy), .err(err),
      .tx_data(tx_data), .tx_len_1(tx_len_1), .tx_send(tx_send), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Entered mid-cycle in IDLE with req already driven; leaves mid-cycle back in IDLE.
   task automatic run_xfer(input logic [N-1:0] g, input logic [31:0] len, input logic [DW-1:0] dat);
      #1;
      chk("xf_grant", 64'(grant), 64'(g));
      tick();
      chk("xf_send", 64'(tx_send), 64'd1);
      chk("xf_owner", 64'(owner), 64'(g));
      chk("xf_len", 64'(tx_len_1), 64'(len));
      chk("xf_data", 64'(tx_data), 64'(dat));
      tick();
      tx_ready = 1'b0;
      #1;
      chk("xf_send_off", 64'(tx_send), 64'd0);
      tick();
      tx_ready = 1'b1;
      #1;
      chk("xf_no_done_early", 64'(done), 64'd0);
      tick();
      #1;
      chk("xf_done", 64'(done), 64'(g));
      tick();
      #1;
      chk("xf_idle_done", 64'(done), 64'd0);
      chk("xf_idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      res_n     = 1'b0;
      req       = 4'b1111;
      tx_ready  = 1'b1;
      req_data  = 64'h4444_3333_2222_00A5;
      req_len_1 = '0;
      req_len_1[1*32 +: 32] = 32'd1;
      #1;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_send", 64'(tx_send), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_txdata", 64'(tx_data), 64'd0);
      chk("rst_txlen", 64'(tx_len_1), 64'd0);
      tick();
      res_n = 1'b1;
      req   = 4'b0001;

      // Single transfer, requester deasserts right after its grant.
      #1;
      chk("t1_grant", 64'(grant), 64'h1);
      chk("t1_idle_send", 64'(tx_send), 64'd0);
      tick();
      req = 4'b0000;
      #1;
      chk("t1_send", 64'(tx_send), 64'd1);
      chk("t1_grant_off", 64'(grant), 64'd0);
      chk("t1_owner", 64'(owner), 64'h1);
      chk("t1_data", 64'(tx_data), 64'h00A5);
      chk("t1_busy", 64'(busy), 64'd1);
      tick();
      tx_ready = 1'b0;
      #1;
      chk("t1_ws_send", 64'(tx_send), 64'd0);
      tick();
      #1;
      chk("t1_wd_done", 64'(done), 64'd0);
      tick();
      tx_ready = 1'b1;
      #1;
      chk("t1_wd_done2", 64'(done), 64'd0);
      tick();
      #1;
      chk("t1_done", 64'(done), 64'h1);
      tick();
      #1;
      chk("t1_idle_owner", 64'(owner), 64'd0);
      chk("t1_idle_busy", 64'(busy), 64'd0);

      // All four requesting: rotation continues from requester 0.
      req = 4'b1111;
      run_xfer(4'b0010, 32'd1, 16'h2222);
      run_xfer(4'b0100, 32'd0, 16'h3333);
      run_xfer(4'b1000, 32'd0, 16'h4444);
      run_xfer(4'b0001, 32'd0, 16'h00A5);
      run_xfer(4'b0010, 32'd1, 16'h2222);

      // Last served is 1: requester 0 wins by wrapping.
      req = 4'b0011;
      run_xfer(4'b0001, 32'd0, 16'h00A5);

      // Watchdog: tx_ready never drops after tx_send.
      req = 4'b0100;
      #1;
      chk("wd_grant", 64'(grant), 64'h4);
      tick();
      chk("wd_send", 64'(tx_send), 64'd1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("wd_wait_err", 64'(err), 64'd0);
         chk("wd_wait_busy", 64'(busy), 64'd1);
      end
      tick();
      chk("wd_err", 64'(err), 64'd1);
      chk("wd_err_done", 64'(done), 64'd0);
      tick();
      req = 4'b0101;
      #1;
      chk("wd_err_off", 64'(err), 64'd0);
      chk("wd_busy_off", 64'(busy), 64'd0);
      chk("wd_owner_off", 64'(owner), 64'd0);
      chk("wd_no_done", 64'(done), 64'd0);
      run_xfer(4'b0100, 32'd0, 16'h3333);

      // No grant while transmitter busy; length clamp; payload held after grant.
      req      = 4'b1000;
      tx_ready = 1'b0;
      req_len_1[3*32 +: 32] = 32'd7;
      req_data[3*DW +: DW]  = 16'hBEEF;
      #1;
      chk("nr_grant", 64'(grant), 64'd0);
      tick();
      chk("nr_grant2", 64'(grant), 64'd0);
      chk("nr_busy", 64'(busy), 64'd0);
      tx_ready = 1'b1;
      #1;
      chk("cl_grant", 64'(grant), 64'h8);
      tick();
      req_data[3*DW +: DW]  = 16'h1234;
      req_len_1[3*32 +: 32] = 32'd0;
      #1;
      chk("cl_len", 64'(tx_len_1), 64'd1);
      chk("cl_data", 64'(tx_data), 64'hBEEF);
      tick();
      tx_ready = 1'b0;
      #1;
      chk("cl_ws_data", 64'(tx_data), 64'hBEEF);
      tick();
      tx_ready = 1'b1;
      tick();
      chk("cl_done", 64'(done), 64'h8);
      chk("cl_done_data", 64'(tx_data), 64'hBEEF);
      chk("cl_done_len", 64'(tx_len_1), 64'd1);
      tick();

      // Reset during WAIT_DONE abandons the frame.
      req = 4'b0001;
      #1;
      chk("rs_grant", 64'(grant), 64'h1);
      tick();
      tick();
      tx_ready = 1'b0;
      tick();
      chk("rs_busy_pre", 64'(busy), 64'd1);
      res_n = 1'b0;
      #1;
      chk("rs_busy", 64'(busy), 64'd0);
      chk("rs_owner", 64'(owner), 64'd0);
      chk("rs_txdata", 64'(tx_data), 64'd0);
      chk("rs_done", 64'(done), 64'd0);
      chk("rs_grant0", 64'(grant), 64'd0);
      tx_ready = 1'b1;
      tick();
      chk("rs_hold_done", 64'(done), 64'd0);
      res_n = 1'b1;
      req   = 4'b1111;
      req_len_1[2*32 +: 32] = 32'hFFFF_FFFF;
      #1;
      chk("rs_last_reset", 64'(grant), 64'h1);
      req = 4'b0100;
      run_xfer(4'b0100, 32'd1, 16'h3333);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL take parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL take parameter DATA_MAX_LEN, default 1, giving the maximum frame length in bytes per transfer.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port res_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req, input, N_REQ bits: level request per requester, held until its grant.
REQ-007 SHALL have port req_data, input, N_REQ*DATA_MAX_LEN*8 bits: payload, slice i for requester i, byte 0 in LSBs.
REQ-008 SHALL have port req_len_1, input, N_REQ*32 bits: byte count minus 1, slice i for requester i.
REQ-009 SHALL have port grant, output, N_REQ bits: one-cycle pulse accepting requester i's request.
REQ-010 SHALL have port done, output, N_REQ bits: one-cycle pulse when requester i's frame has fully left the line.
REQ-011 SHALL have port owner, output, N_REQ bits: one-hot current transfer owner, zero when idle.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on start watchdog expiry.
REQ-014 SHALL have port tx_data, output, DATA_MAX_LEN*8 bits: registered payload to the shared UART transmitter.
REQ-015 SHALL have port tx_len_1, output, 32 bits: registered byte count minus 1 to the transmitter.
REQ-016 SHALL have port tx_send, output, 1 bit: one-cycle send strobe to the transmitter.
REQ-017 SHALL have port tx_ready, input, 1 bit: transmitter ready (idle, or final stop-bit cycle).

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT_START, WAIT_DONE and DONE.
REQ-021 SHALL, in IDLE with tx_ready=1 and any req set, select the winner round-robin: the first set req bit scanning from (last+1) mod N_REQ upward with wrap.
REQ-022 SHALL, in that same cycle, pulse grant[winner], latch its data and clamped length into tx_data/tx_len_1, set owner, and go to ISSUE.
REQ-023 SHALL NOT grant while tx_ready=0 in IDLE; requests stay pending without loss.
REQ-024 SHALL clamp the latched length to DATA_MAX_LEN-1 when req_len_1 exceeds DATA_MAX_LEN-1 (unsigned compare).
REQ-025 SHALL assert tx_send for exactly the one cycle spent in ISSUE, then go to WAIT_START with the watchdog cleared.
REQ-026 SHALL leave WAIT_START for WAIT_DONE on the first cycle tx_ready=0.
REQ-027 SHALL, if tx_ready is still 1 after 4 cycles in WAIT_START, pulse err, clear owner, keep last unchanged, issue no done, and return to IDLE.
REQ-028 SHALL leave WAIT_DONE for DONE on the first cycle tx_ready=1.
REQ-029 SHALL, in DONE, pulse done[owner] for one cycle, set last to the owner index, clear owner and return to IDLE.
REQ-030 SHALL hold tx_data/tx_len_1 stable from ISSUE through DONE, whatever req_data does.
REQ-031 SHALL ignore a requester deasserting req after grant; the granted transfer completes.
REQ-032 SHALL give a new request arriving in DONE no priority; it is arbitrated normally in IDLE next cycle.
REQ-033 SHALL keep grant, done, tx_send and err one-hot-or-zero and never high together for different requesters.
REQ-034 SHALL take the minimum request-to-tx_send latency as 1 cycle: grant in cycle T, tx_send in cycle T+1.

Reset
REQ-040 SHALL, while res_n=0, asynchronously force state IDLE; grant, done, owner, busy, err, tx_send at 0; tx_data, tx_len_1 at 0; last at N_REQ-1, so requester 0 is first.
REQ-041 SHALL, on reset mid-transfer, abandon the transfer without a done pulse; the transmitter is reset by the system alongside.

Verification
REQ-050 SHALL cover this case: req=0001, len_1=0, tx_ready=1 -> grant=0001 at T, tx_send at T+1, done=0001 one cycle after tx_ready returns high.
REQ-051 SHALL cover this case: req=1111 held continuously -> grants in order 0001,0010,0100,1000,0001 with one done between each.
REQ-052 SHALL cover this case: last=1 (requester 1 served) and req=0011 -> next grant=0001 (wrap past 2,3), not 0010.
REQ-053 SHALL cover this case: tx_ready stuck 1 after tx_send -> err pulse 5 cycles after tx_send, then busy=0, no done, and the same requester is re-granted if still requesting.
REQ-054 SHALL cover this case: DATA_MAX_LEN=2, req_len_1=7 -> tx_len_1=1; and req_data changed after grant -> tx_data unchanged.
REQ-055 SHALL cover this case: res_n=0 in WAIT_DONE -> all outputs 0 immediately, no done; after release, req=0100 -> grant=0100.
